ramen: RTL and testbench

RAMEN -- requirements
Module: ramen

---
 rtl/ramen.sv | 199 +++++++++++++++++++
 tb/tb_ramen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ramen.sv
// ramen: MM:SS countdown timer with a multiplexed 4-digit seven-segment display.
//
// Ports
//   clk      rising-edge clock, the only clock
//   reset    synchronous active-high reset
//   in       [12] start/run switch, [11:6] preset minutes, [5:0] preset seconds
//   cathode  active-low segments of the digit currently enabled (bit0=a .. bit6=g)
//   AN       active-low digit enables: [3] min tens, [2] min ones, [1] sec tens, [0] sec ones
//   timeUp   high while the timer sits expired (DONE state)
//
// Parameters
//   CLK_HZ          clock cycles per one-second countdown tick
//   REFRESH_CYCLES  clock cycles each display digit stays enabled
module ramen #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] in,
  output logic [6:0]  cathode,
  output logic [3:0]  AN,
  output logic        timeUp
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q;
  logic           start_q;
  logic [5:0]     mm_q;
  logic [5:0]     ss_q;
  logic [PW-1:0]  presc_q;
  logic           time_up_q;

  logic [SW-1:0]  scan_cnt_q;
  logic [1:0]     scan_idx_q;
  logic [3:0]     an_q;
  logic [6:0]     cathode_q;

  // Preset switches, clamped to a legal 0..59 field.
  logic [5:0] preset_mm;
  logic [5:0] preset_ss;
  assign preset_mm = (in[11:6] > 6'd59) ? 6'd59 : in[11:6];
  assign preset_ss = (in[5:0]  > 6'd59) ? 6'd59 : in[5:0];

  logic start_edge;
  logic tick;
  assign start_edge = in[12] & ~start_q;
  assign tick       = (presc_q == PRESC_LAST);

  // One-second decrement with borrow from minutes.
  logic [5:0] mm_d;
  logic [5:0] ss_d;
  logic       dec_zero;
  always_comb begin
    mm_d = mm_q;
    ss_d = ss_q;
    if (ss_q != 6'd0) begin
      ss_d = ss_q - 6'd1;
    end else if (mm_q != 6'd0) begin
      ss_d = 6'd59;
      mm_d = mm_q - 6'd1;
    end
  end
  assign dec_zero = (mm_d == 6'd0) && (ss_d == 6'd0);

  // Timer state machine; timeUp is registered alongside the state so it is
  // high exactly while the state is DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b1;  // a start switch held through reset is not an edge
      mm_q      <= 6'd0;
      ss_q      <= 6'd0;
      presc_q   <= '0;
      time_up_q <= 1'b0;
    end else begin
      start_q <= in[12];
      case (state_q)
        IDLE: begin
          mm_q      <= preset_mm;
          ss_q      <= preset_ss;
          time_up_q <= 1'b0;
          if (start_edge) begin
            state_q <= RUN;
            presc_q <= '0;
          end
        end
        RUN: begin
          if (!in[12]) begin
            state_q   <= IDLE;
            mm_q      <= preset_mm;
            ss_q      <= preset_ss;
            time_up_q <= 1'b0;
          end else if (mm_q == 6'd0 && ss_q == 6'd0) begin
            // started from 00:00: expire without waiting for a tick
            state_q   <= DONE;
            time_up_q <= 1'b1;
          end else if (tick) begin
            presc_q <= '0;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            if (dec_zero) begin
              state_q   <= DONE;
              time_up_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        DONE: begin
          if (!in[12]) begin
            state_q   <= IDLE;
            mm_q      <= preset_mm;
            ss_q      <= preset_ss;
            time_up_q <= 1'b0;
          end else begin
            mm_q      <= 6'd0;
            ss_q      <= 6'd0;
            time_up_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          time_up_q <= 1'b0;
        end
      endcase
    end
  end

  // Digit value for the current scan index.
  logic [3:0] digit_val;
  always_comb begin
    digit_val = 4'd0;
    case (scan_idx_q)
      2'd0: digit_val = 4'(ss_q % 6'd10);
      2'd1: digit_val = 4'(ss_q / 6'd10);
      2'd2: digit_val = 4'(mm_q % 6'd10);
      2'd3: digit_val = 4'(mm_q / 6'd10);
      default: digit_val = 4'd0;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [6:0] cathode_d;
  logic [3:0] an_d;
  assign cathode_d = seg7(digit_val);
  assign an_d      = ~(4'b0001 << scan_idx_q);

  // Display scan; outputs are registered so they trail the scan index by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      an_q       <= 4'b1110;
      cathode_q  <= 7'b1000000;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
      end
      an_q      <= an_d;
      cathode_q <= cathode_d;
    end
  end

  assign cathode = cathode_q;
  assign AN      = an_q;
  assign timeUp  = time_up_q;

endmodule

// File: tb/tb_ramen.sv
// Testbench for ramen (CLK_HZ=10, REFRESH_CYCLES=2). Stimulus pushes expected
// display/timeUp items into a queue; a monitor pops them and compares when the
// DUT presents the matching digit (or at once for immediate items).
module tb_ramen;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] sw;
  logic [6:0]  cathode;
  logic [3:0]  AN;
  logic        timeUp;

  always #5 clk = ~clk;

  ramen #(.CLK_HZ(10), .REFRESH_CYCLES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (sw),
    .cathode (cathode),
    .AN      (AN),
    .timeUp  (timeUp)
  );

  typedef struct {
    string      name;
    int         pos;   // 0..3 digit position, 4 = timeUp only
    logic [6:0] cath;
    logic       tu;
    bit         imm;   // compare at the next sample instead of waiting for the digit
  } item_t;

  item_t sb_q[$];
  bit    mon_busy = 1'b0;
  int    errors = 0;
  int    checks = 0;

  function automatic logic [6:0] seg(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b1000000;
      1: s = 7'b1111001;
      2: s = 7'b0100100;
      3: s = 7'b0110000;
      4: s = 7'b0011001;
      5: s = 7'b0010010;
      6: s = 7'b0000010;
      7: s = 7'b1111000;
      8: s = 7'b0000000;
      9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end else begin
      $display("ok   %s: %b", nm, act);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    item_t      cur;
    int         waited;
    logic [3:0] exp_an;
    waited = 0;
    forever begin
      @(negedge clk);
      if (!mon_busy && sb_q.size() > 0) begin
        cur      = sb_q.pop_front();
        mon_busy = 1'b1;
        waited   = 0;
      end
      if (mon_busy) begin
        exp_an = ~(4'b0001 << cur.pos[1:0]);
        if (cur.imm || (cur.pos < 4 && AN === exp_an)) begin
          if (cur.pos < 4) begin
            if (cur.imm) chk({cur.name, ".an"}, {4'b0, AN}, {4'b0, exp_an});
            chk({cur.name, ".cathode"}, {1'b0, cathode}, {1'b0, cur.cath});
          end
          chk({cur.name, ".timeUp"}, {7'b0, timeUp}, {7'b0, cur.tu});
          mon_busy = 1'b0;
        end else if (waited >= 12) begin
          checks++;
          errors++;
          $display("FAIL %s: digit %0d never shown, AN=%b", cur.name, cur.pos, AN);
          mon_busy = 1'b0;
        end else begin
          waited++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input int pos, input logic [6:0] c,
                      input logic tu, input bit imm);
    item_t it;
    it.name = nm;
    it.pos  = pos;
    it.cath = c;
    it.tu   = tu;
    it.imm  = imm;
    sb_q.push_back(it);
  endtask

  task automatic show(input string nm, input int mm, input int ss, input logic tu);
    push({nm, ".d0"}, 0, seg(ss % 10), tu, 1'b0);
    push({nm, ".d1"}, 1, seg(ss / 10), tu, 1'b0);
    push({nm, ".d2"}, 2, seg(mm % 10), tu, 1'b0);
    push({nm, ".d3"}, 3, seg(mm / 10), tu, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() > 0 || mon_busy) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d items pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    sw    = 13'd0;
    tick(1);
    push("rst_state", 0, 7'b1000000, 1'b0, 1'b1);
    reset = 1'b0;
    tick(2);
    show("rst_zero", 0, 0, 1'b0);
    drain();

    // Preset display 01:03
    sw = {1'b0, 6'd1, 6'd3};
    tick(2);
    show("preset", 1, 3, 1'b0);
    drain();

    // Countdown from 00:03
    sw = {1'b0, 6'd0, 6'd3};
    tick(2);
    sw = {1'b1, 6'd0, 6'd3};
    tick(1);                                  // start edge: RUN entered
    tick(10);                                 // first tick -> 00:02
    tick(1);
    push("cd_02", 0, seg(2), 1'b0, 1'b0);
    tick(10);                                 // after 21 edges: 00:01
    push("cd_01", 0, seg(1), 1'b0, 1'b0);
    tick(8);                                  // 29 edges: not yet expired
    push("cd_pre", 4, 7'd0, 1'b0, 1'b1);
    tick(1);                                  // 30 edges: expired
    push("cd_done", 4, 7'd0, 1'b1, 1'b1);
    tick(1);
    show("done", 0, 0, 1'b1);
    drain();

    // Leave DONE: timeUp clears, preset reloads
    sw = {1'b0, 6'd0, 6'd3};
    tick(1);
    push("done_exit", 4, 7'd0, 1'b0, 1'b1);
    tick(1);
    show("reload", 0, 3, 1'b0);
    drain();

    // Borrow: 01:00 -> 00:59
    sw = {1'b0, 6'd1, 6'd0};
    tick(2);
    sw = {1'b1, 6'd1, 6'd0};
    tick(1);
    tick(10);
    tick(1);
    push("borrow.d0", 0, seg(9), 1'b0, 1'b0);
    push("borrow.d1", 1, seg(5), 1'b0, 1'b0);
    push("borrow.d2", 2, seg(0), 1'b0, 1'b0);
    drain();

    // Clamp 63:63 -> 59:59
    sw = {1'b0, 6'h3f, 6'h3f};
    tick(2);
    show("clamp", 59, 59, 1'b0);
    drain();

    // Abort at 00:40; switch changes during RUN are ignored
    sw = {1'b0, 6'd0, 6'd41};
    tick(2);
    sw = {1'b1, 6'd0, 6'd41};
    tick(1);
    tick(10);                                 // 00:40
    sw = {1'b1, 6'd12, 6'd7};
    tick(1);
    push("run40.d0", 0, seg(0), 1'b0, 1'b0);
    push("run40.d1", 1, seg(4), 1'b0, 1'b0);
    push("run40.d3", 3, seg(0), 1'b0, 1'b0);
    drain();
    sw = {1'b0, 6'd12, 6'd7};
    tick(1);
    push("abort_tu", 4, 7'd0, 1'b0, 1'b1);
    tick(1);
    show("abort_reload", 12, 7, 1'b0);
    drain();

    // Start held high through reset does not start the timer
    sw    = {1'b1, 6'd0, 6'd5};
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);
    show("held_start", 0, 5, 1'b0);
    drain();

    // Reset while in DONE
    sw = {1'b0, 6'd0, 6'd1};
    tick(2);
    sw = {1'b1, 6'd0, 6'd1};
    tick(1);
    tick(10);
    push("done_tu", 4, 7'd0, 1'b1, 1'b1);
    reset = 1'b1;
    tick(1);
    push("rst_done", 0, 7'b1000000, 1'b0, 1'b1);
    reset = 1'b0;
    tick(2);
    show("rst_done_idle", 0, 1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
